// File: rtl/pwm_timer.sv
// Double-buffered PWM timer: edge-aligned by default, center-aligned counting
// when PWM_TIMER_CENTER_EN is defined. Shadow period/compare move to active only at wrap.
module pwm_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             wr_period,
  input  logic [WIDTH-1:0] period_in,
  input  logic             wr_cmp,
  input  logic [WIDTH-1:0] cmp_in,
  output logic [WIDTH-1:0] cnt,
  output logic             pwm,
  output logic             ovf,
  output logic             cmp_match,
  output logic             pending
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifdef PWM_TIMER_CENTER_EN
  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_e;
  dir_e dir_q, dir_d;
  logic mode_q, mode_d;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic [WIDTH-1:0] period_s_q, period_s_d;
  logic [WIDTH-1:0] cmp_s_q, cmp_s_d;
  logic             pend_q, pend_d;
  logic             pwm_q, pwm_d;
  logic             ovf_q, ovf_d;
  logic             match_q, match_d;
  logic             upd;

  always_comb begin
    cnt_d      = cnt_q;
    period_d   = period_q;
    cmp_d      = cmp_q;
    period_s_d = period_s_q;
    cmp_s_d    = cmp_s_q;
    pend_d     = pend_q;
    upd        = 1'b0;
`ifdef PWM_TIMER_CENTER_EN
    dir_d      = dir_q;
    mode_d     = mode_q;
`endif

    if (en) begin
`ifdef PWM_TIMER_CENTER_EN
      if (mode_q) begin
        if (period_q == '0) begin
          upd   = 1'b1;
          cnt_d = '0;
          dir_d = DIR_UP;
        end else if (dir_q == DIR_DN) begin
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) begin
            upd   = 1'b1;
            dir_d = DIR_UP;
          end
        end else begin
          // Turn around on arrival at the top so the top value is shown once.
          cnt_d = cnt_q + ONE;
          if (cnt_d == period_q) dir_d = DIR_DN;
        end
      end else
`endif
      begin
        if (cnt_q == period_q) begin
          upd   = 1'b1;
          cnt_d = '0;
`ifdef PWM_TIMER_CENTER_EN
          dir_d = DIR_UP;
`endif
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    end

    if (upd) begin
      period_d = period_s_q;
      cmp_d    = cmp_s_q;
      pend_d   = 1'b0;
`ifdef PWM_TIMER_CENTER_EN
      mode_d   = mode;
`endif
    end

    // A write on the update clock lands after the transfer, so pending stays set.
    if (wr_period) begin
      period_s_d = period_in;
      pend_d     = 1'b1;
    end
    if (wr_cmp) begin
      cmp_s_d = cmp_in;
      pend_d  = 1'b1;
    end

    pwm_d   = (cnt_d < cmp_d);
    ovf_d   = upd;
    // A counter that is re-loaded with the same value (period 0) is not a new match.
    match_d = en && (cnt_d == cmp_d) && (cnt_d != cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      period_q   <= '0;
      cmp_q      <= '0;
      period_s_q <= '0;
      cmp_s_q    <= '0;
      pend_q     <= 1'b0;
      pwm_q      <= 1'b0;
      ovf_q      <= 1'b0;
      match_q    <= 1'b0;
`ifdef PWM_TIMER_CENTER_EN
      dir_q      <= DIR_UP;
      mode_q     <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      cmp_q      <= cmp_d;
      period_s_q <= period_s_d;
      cmp_s_q    <= cmp_s_d;
      pend_q     <= pend_d;
      pwm_q      <= pwm_d;
      ovf_q      <= ovf_d;
      match_q    <= match_d;
`ifdef PWM_TIMER_CENTER_EN
      dir_q      <= dir_d;
      mode_q     <= mode_d;
`endif
    end
  end

  assign cnt       = cnt_q;
  assign pwm       = pwm_q;
  assign ovf       = ovf_q;
  assign cmp_match = match_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_pwm_timer.sv
// Randomized bench for pwm_timer against a position-in-period model, plus
// hand-computed checks for startup, reset-with-pending and the model itself.
module tb_pwm_timer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, en, mode, wr_period, wr_cmp;
  logic [W-1:0] period_in, cmp_in;
  logic [W-1:0] cnt;
  logic         pwm, ovf, cmp_match, pending;

  pwm_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .wr_period(wr_period), .period_in(period_in),
    .wr_cmp(wr_cmp), .cmp_in(cmp_in),
    .cnt(cnt), .pwm(pwm), .ovf(ovf), .cmp_match(cmp_match), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: the waveform is a function of the position inside the current period.
  int unsigned m_per, m_cmp, m_per_s, m_cmp_s, m_pos;
  bit          m_mode, m_pend, model_live;
  int unsigned e_cnt;
  bit          e_pwm, e_ovf, e_match;

  function automatic int unsigned cnt_of(int unsigned pos, int unsigned per, bit md);
    if (md && pos > per) return 2 * per - pos;
    return pos;
  endfunction

  always @(posedge clk) begin
    int unsigned len, old_cnt;
    bit wrap;
    if (rst) begin
      m_per = 0; m_cmp = 0; m_per_s = 0; m_cmp_s = 0; m_pos = 0;
      m_mode = 0; m_pend = 0;
      e_cnt = 0; e_pwm = 0; e_ovf = 0; e_match = 0;
      model_live = 1;
    end else begin
      wrap = 0;
      old_cnt = e_cnt;
      if (en) begin
        if (m_per == 0) len = 1;
        else if (m_mode) len = 2 * m_per;
        else len = m_per + 1;
        m_pos++;
        if (m_pos >= len) begin
          m_pos = 0;
          wrap = 1;
        end
      end
      if (wrap) begin
        m_per = m_per_s; m_cmp = m_cmp_s; m_pend = 0;
`ifdef PWM_TIMER_CENTER_EN
        m_mode = mode;
`else
        m_mode = 0;
`endif
      end
      if (wr_period) begin m_per_s = period_in; m_pend = 1; end
      if (wr_cmp)    begin m_cmp_s = cmp_in;    m_pend = 1; end
      e_cnt   = cnt_of(m_pos, m_per, m_mode);
      e_pwm   = (e_cnt < m_cmp);
      e_ovf   = wrap;
      e_match = en && (e_cnt == m_cmp) && (e_cnt != old_cnt);
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("cnt", int'(cnt), int'(e_cnt));
      chk("pwm", int'(pwm), int'(e_pwm));
      chk("ovf", int'(ovf), int'(e_ovf));
      chk("cmp_match", int'(cmp_match), int'(e_match));
      chk("pending", int'(pending), int'(m_pend));
    end
  end

  initial begin
    int exp_cnt[5] = '{1, 2, 3, 4, 0};
    int exp_pwm[5] = '{1, 0, 0, 0, 1};
    int exp_ovf[5] = '{0, 0, 0, 0, 1};
    int exp_mat[5] = '{0, 1, 0, 0, 0};
    int pc;
    model_live = 0;
    rst = 1; en = 0; mode = 0; wr_period = 0; wr_cmp = 0;
    period_in = '0; cmp_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_cnt", int'(cnt), 0);
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_match", int'(cmp_match), 0);
    chk("reset_pending", int'(pending), 0);

    // Startup: period=4, cmp=2 written while period_r is still 0.
    rst = 0; en = 1;
    wr_period = 1; period_in = 8'd4;
    wr_cmp = 1; cmp_in = 8'd2;
    @(negedge clk);
    wr_period = 0; wr_cmp = 0;
    chk("start_pending", int'(pending), 1);
    chk("start_cnt", int'(cnt), 0);
    @(negedge clk);
    chk("xfer_cnt", int'(cnt), 0);
    chk("xfer_pwm", int'(pwm), 1);
    chk("xfer_ovf", int'(ovf), 1);
    chk("xfer_pending", int'(pending), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("seq_cnt", int'(cnt), exp_cnt[i]);
      chk("seq_pwm", int'(pwm), exp_pwm[i]);
      chk("seq_ovf", int'(ovf), exp_ovf[i]);
      chk("seq_match", int'(cmp_match), exp_mat[i]);
    end
    // Now cnt=0; write cmp=4 at cnt=1, effective only after the wrap.
    @(negedge clk);
    chk("mid_cnt", int'(cnt), 1);
    wr_cmp = 1; cmp_in = 8'd4;
    @(negedge clk);
    wr_cmp = 0;
    chk("mid_pending", int'(pending), 1);
    chk("mid_pwm_old", int'(pwm), 0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("new_cnt", int'(cnt), 0);
    chk("new_pwm", int'(pwm), 1);
    chk("new_pending", int'(pending), 0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("new_pwm_cnt3", int'(pwm), 1);
    @(negedge clk);
    chk("new_pwm_cnt4", int'(pwm), 0);

    // Randomized phase against the model.
    for (int cyc = 0; cyc < 6000; cyc++) begin
      rst  = ($urandom_range(0, 399) == 0);
      en   = ($urandom_range(0, 3) != 0);
      mode = $urandom_range(0, 1);
      wr_period = ($urandom_range(0, 23) == 0);
      wr_cmp    = ($urandom_range(0, 23) == 0);
      pc = $urandom_range(0, 5);
      case (pc)
        0: period_in = 8'd0;
        1: period_in = 8'd1;
        2: period_in = 8'd2;
        3: period_in = 8'd4;
        4: period_in = 8'd255;
        default: period_in = W'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 3))
        0: cmp_in = 8'd0;
        1: cmp_in = period_in;
        2: cmp_in = period_in + 8'd1;
        default: cmp_in = W'($urandom_range(0, 255));
      endcase
      @(negedge clk);
    end

    // Reset with a pending shadow write discards the shadow.
    rst = 0; en = 1; wr_cmp = 0; mode = 0;
    wr_period = 1; period_in = 8'd7;
    @(negedge clk);
    wr_period = 0;
    chk("rstp_pending", int'(pending), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstp_cnt", int'(cnt), 0);
    chk("rstp_pwm", int'(pwm), 0);
    chk("rstp_pending_clr", int'(pending), 0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("rstp_shadow_lost", int'(cnt), 0);
    chk("rstp_ovf_every_tick", int'(ovf), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
